// File: rtl/wb_uart_tx_pkg.sv
// wb_uart_tx_pkg: register offsets, STATUS bit layout and serializer state encoding,
// shared by the UART transmitter RTL and its bench.
package wb_uart_tx_pkg;
  localparam logic [2:0] ADR_TXDATA  = 3'd0;
  localparam logic [2:0] ADR_STATUS  = 3'd1;
  localparam logic [2:0] ADR_DIVISOR = 3'd2;
  localparam logic [2:0] ADR_IRQ_EN  = 3'd3;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_COUNT = 4;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;
endpackage

// File: rtl/sync_fifo_byte.sv
// sync_fifo_byte: byte FIFO of 2**ADR_WIDTH entries with combinational head data;
// pushes when full and pops when empty are ignored.
module sync_fifo_byte #(
  parameter int ADR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [7:0]           din,
  input  logic                 pop,
  output logic [7:0]           dout,
  output logic                 full,
  output logic                 empty,
  output logic [ADR_WIDTH:0]   count
);
  localparam int DEPTH = 1 << ADR_WIDTH;
  logic [7:0]           mem_q [DEPTH];
  logic [ADR_WIDTH-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [ADR_WIDTH:0]   cnt_q, cnt_d;
  logic                 do_push, do_pop;
  always_comb begin
    full    = cnt_q == (ADR_WIDTH+1)'(DEPTH);
    empty   = cnt_q == '0;
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wr_d    = wr_q + ADR_WIDTH'(do_push);
    rd_d    = rd_q + ADR_WIDTH'(do_pop);
    cnt_d   = cnt_q + (ADR_WIDTH+1)'(do_push) - (ADR_WIDTH+1)'(do_pop);
    dout    = mem_q[rd_q];
    count   = cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone classic slave with a byte FIFO feeding an 8N1 serializer;
// bit period is DIVISOR+1 clocks, interrupt flags an empty and idle transmitter.
module wb_uart_tx
  import wb_uart_tx_pkg::*;
#(
  parameter int          FIFO_ADR_WIDTH = 4,
  parameter logic [15:0] RESET_DIVISOR  = 16'd433
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [23:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        uart_int_o,
  output logic        uart_tx_o
);
  logic [7:0]              rd_data;
  logic                    full, empty, push, pop;
  logic [FIFO_ADR_WIDTH:0] count;
  logic                    req, wr, tx_wr, bit_end;
  logic [2:0]              adr;
  logic [31:0]             status, rd_mux;
  logic                    ack_q, ack_d, err_q, err_d, irq_q, irq_d, int_q, int_d;
  logic [31:0]             dat_q, dat_d;
  logic [15:0]             div_q, div_d, cnt_q, cnt_d;
  logic [7:0]              sh_q, sh_d;
  logic [2:0]              idx_q, idx_d;
  tx_state_e               state_q, state_d;
  logic                    unused_ok;
  assign unused_ok = ^{wb_dat_i[31:16], wb_adr_i[23:5], wb_adr_i[1:0], wb_sel_i[3:2]};
  sync_fifo_byte #(.ADR_WIDTH(FIFO_ADR_WIDTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .push  (push),
    .din   (wb_dat_i[7:0]),
    .pop   (pop),
    .dout  (rd_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // A request is only accepted when the previous cycle did not terminate one,
  // so a held strobe after ack/err is never mistaken for a second transfer.
  always_comb begin
    req    = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    adr    = wb_adr_i[4:2];
    wr     = req & wb_we_i;
    tx_wr  = wr & (adr == ADR_TXDATA) & wb_sel_i[0];
    push   = tx_wr & ~full;
    err_d  = req & (adr[2] | (tx_wr & full));
    ack_d  = req & ~err_d;
    status = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL]  = full;
    status[ST_BUSY]  = state_q != S_IDLE;
    status[ST_COUNT +: FIFO_ADR_WIDTH+1] = count;
    rd_mux = adr == ADR_STATUS  ? status :
             adr == ADR_DIVISOR ? {16'd0, div_q} :
             adr == ADR_IRQ_EN  ? {31'd0, irq_q} : '0;
    dat_d  = (ack_d & ~wb_we_i) ? rd_mux : '0;
    div_d  = (wr & (adr == ADR_DIVISOR)) ?
             {wb_sel_i[1] ? wb_dat_i[15:8] : div_q[15:8], wb_sel_i[0] ? wb_dat_i[7:0] : div_q[7:0]} : div_q;
    irq_d  = (wr & (adr == ADR_IRQ_EN) & wb_sel_i[0]) ? wb_dat_i[0] : irq_q;
    int_d  = irq_q & empty & (state_q == S_IDLE);
  end
  // The bit counter reloads from DIVISOR at every bit boundary (and continuously
  // in IDLE), so a DIVISOR write only affects the bit that starts after it.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    bit_end = cnt_q == 16'd0;
    cnt_d   = (bit_end || state_q == S_IDLE) ? div_q : cnt_q - 16'd1;
    case (state_q)
      S_IDLE:
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = rd_data;
          state_d = S_START;
        end
      S_START:
        if (bit_end) begin
          idx_d   = 3'd0;
          state_d = S_DATA;
        end
      S_DATA:
        if (bit_end) begin
          sh_d    = sh_q >> 1;
          idx_d   = idx_q + 3'd1;
          state_d = idx_q == 3'd7 ? S_STOP : S_DATA;
        end
      S_STOP:
        if (bit_end) begin
          pop     = ~empty;
          sh_d    = empty ? sh_q : rd_data;
          state_d = empty ? S_IDLE : S_START;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      div_q   <= RESET_DIVISOR;
      irq_q   <= 1'b0;
      int_q   <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      div_q   <= div_d;
      irq_q   <= irq_d;
      int_q   <= int_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
    end
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_dat_o   = dat_q;
  assign uart_int_o = int_q;
  assign uart_tx_o  = state_q == S_START ? 1'b0 : state_q == S_DATA ? sh_q[0] : 1'b1;
endmodule

// File: tb/tb_wb_uart_tx.sv
// tb_wb_uart_tx: directed corner cases plus random bus traffic, checked every cycle
// against a queue-of-bytes / list-of-line-bits model of the transmitter.
module tb_wb_uart_tx;
  import wb_uart_tx_pkg::*;
  localparam int DEPTH = 16;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] d_i = '0, d_o;
  logic [23:0] adr_i = '0;
  logic [3:0]  sel_i = '0;
  logic        we_i = 1'b0, cyc_i = 1'b0, stb_i = 1'b0;
  logic        ack_o, err_o, int_o, tx_o;
  int          n_chk = 0, n_fail = 0;
  logic [7:0]  mq[$];
  logic        mbits[$];
  int          m_rem;
  logic [15:0] m_div;
  logic        m_irq, m_ack, m_err, m_int;
  logic [31:0] m_dat;

  wb_uart_tx #(.FIFO_ADR_WIDTH(4), .RESET_DIVISOR(16'd433)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_dat_i(d_i), .wb_dat_o(d_o),
    .wb_adr_i(adr_i), .wb_sel_i(sel_i), .wb_we_i(we_i), .wb_cyc_i(cyc_i),
    .wb_stb_i(stb_i), .wb_ack_o(ack_o), .wb_err_o(err_o),
    .uart_int_o(int_o), .uart_tx_o(tx_o));

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete(); mbits.delete();
    m_rem = 0; m_div = 16'd433; m_irq = 0; m_ack = 0; m_err = 0; m_int = 0; m_dat = '0;
  endfunction

  function automatic void start_frame();
    logic [7:0] b;
    b = mq.pop_front();
    mbits.delete();
    mbits.push_back(1'b0);
    for (int i = 0; i < 8; i++) mbits.push_back(b[i]);
    mbits.push_back(1'b1);
    m_rem = int'(m_div) + 1;
  endfunction

  // One clock edge of the reference: frame bits first (pre-edge divisor and
  // queue), then the bus transfer decided on the pre-edge occupancy.
  function automatic void model_step();
    int cnt; logic empty, full, busy, req, n_int; logic [2:0] a; logic [31:0] st;
    cnt = mq.size(); empty = cnt == 0; full = cnt == DEPTH; busy = mbits.size() != 0;
    st = (32'(cnt) << 4) | (32'(busy) << 2) | (32'(full) << 1) | 32'(empty);
    req = cyc_i & stb_i & !m_ack & !m_err;
    a = adr_i[4:2];
    n_int = m_irq & empty & !busy;
    if (!busy) begin
      if (!empty) start_frame();
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        void'(mbits.pop_front());
        if (mbits.size() == 0) begin
          if (!empty) start_frame();
        end else m_rem = int'(m_div) + 1;
      end
    end
    m_ack = 0; m_err = 0; m_dat = '0;
    if (req) begin
      if (a >= 4 || (a == 0 && we_i && sel_i[0] && full)) m_err = 1;
      else begin
        m_ack = 1;
        if (we_i) begin
          if (a == 0 && sel_i[0]) mq.push_back(d_i[7:0]);
          if (a == 2 && sel_i[0]) m_div[7:0] = d_i[7:0];
          if (a == 2 && sel_i[1]) m_div[15:8] = d_i[15:8];
          if (a == 3 && sel_i[0]) m_irq = d_i[0];
        end else
          m_dat = a == 1 ? st : a == 2 ? {16'd0, m_div} : a == 3 ? {31'd0, m_irq} : 32'd0;
      end
    end
    m_int = n_int;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset(); else model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("line", tx_o, mbits.size() != 0 ? mbits[0] : 1'b1);
      chk("irq", int_o, m_int);
      chk("ack", ack_o, m_ack);
      chk("err", err_o, m_err);
      chk("rdata", d_o, m_dat);
    end
  end

  task automatic xfer(input logic we, input logic [23:0] adr, input logic [31:0] d, input logic [3:0] sel,
                      output logic ack, output logic err, output logic [31:0] rd);
    cyc_i = 1; stb_i = 1; we_i = we; adr_i = adr; d_i = d; sel_i = sel;
    ack = 0; err = 0; rd = '0;
    for (int i = 0; i < 8 && !(ack | err); i++) begin
      @(posedge clk); #1;
      ack = ack_o; err = err_o; rd = d_o;
    end
    cyc_i = 0; stb_i = 0; we_i = 0;
    n_chk++;
    if (!(ack | err)) begin
      n_fail++;
      $display("FAIL xfer_timeout: no ack or err for adr 0x%0h", adr);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic k, e; logic [31:0] r;
    xfer(1'b1, {19'd0, a, 2'b00}, d, 4'hF, k, e, r);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    logic k, e;
    xfer(1'b0, {19'd0, a, 2'b00}, 32'd0, 4'hF, k, e, v);
  endtask

  initial begin
    logic [31:0] v; logic k, e; int rise, lows;
    logic [9:0]  fr1;
    logic [19:0] fr2;
    fr1 = {1'b1, 8'hA5, 1'b0};
    fr2 = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_line", tx_o, 1); chk("rst_ack", ack_o, 0); chk("rst_err", err_o, 0);
    chk("rst_dat", d_o, 0); chk("rst_int", int_o, 0);
    rst_n = 1;
    @(posedge clk); #1;
    rd(ADR_STATUS, v);  chk("status_reset", v, 32'h1);
    rd(ADR_DIVISOR, v); chk("divisor_reset", v, 32'd433);
    // single byte frame at 4 clocks per bit
    wr(ADR_DIVISOR, 32'd3);
    wr(ADR_TXDATA, 32'hA5);
    @(negedge clk); chk("a5_idle_before", tx_o, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); chk("a5_wave", tx_o, fr1[i/4]);
    end
    @(posedge clk); #1;
    rd(ADR_STATUS, v); chk("status_after_a5", v, 32'h1);
    // bus corner cases
    xfer(1'b0, 24'h14, 32'd0, 4'hF, k, e, v);
    chk("off14_err", e, 1); chk("off14_ack", k, 0);
    xfer(1'b1, 24'h0, 32'h77, 4'b1110, k, e, v);
    chk("sel0_ack", k, 1);
    rd(ADR_STATUS, v); chk("sel0_count", v, 32'h1);
    wr(ADR_DIVISOR, 32'h01B1);
    xfer(1'b1, 24'h8, 32'h1234, 4'b0001, k, e, v);
    rd(ADR_DIVISOR, v); chk("div_lane", v, 32'h0134);
    // back-to-back frames at one clock per bit
    wr(ADR_DIVISOR, 32'd0);
    wr(ADR_TXDATA, 32'h00);
    fork
      wr(ADR_TXDATA, 32'hFF);
      begin
        @(negedge clk); chk("b2b_idle_before", tx_o, 1);
        for (int i = 0; i < 20; i++) begin
          @(negedge clk); chk("b2b_wave", tx_o, fr2[i]);
        end
      end
    join
    repeat (10) @(posedge clk); #1;
    // interrupt
    wr(ADR_IRQ_EN, 32'd1);
    repeat (2) @(posedge clk); #1;
    chk("int_idle", int_o, 1);
    wr(ADR_TXDATA, 32'h5A);
    @(negedge clk); chk("int_hold", int_o, 1);
    rise = 0;
    for (int i = 1; i <= 40 && rise == 0; i++) begin
      @(negedge clk);
      if (i == 1) chk("int_drop", int_o, 0);
      if (int_o) rise = i;
    end
    chk("int_rise_cycle", rise, 12);
    @(posedge clk); #1;
    wr(ADR_IRQ_EN, 32'd0);
    // FIFO full
    wr(ADR_DIVISOR, 32'hFFFF);
    for (int i = 1; i <= 18; i++) begin
      xfer(1'b1, 24'h0, 32'(i), 4'h1, k, e, v);
      chk(i <= 17 ? "full_ack" : "full_err", {k, e}, i <= 17 ? 2'b10 : 2'b01);
    end
    rd(ADR_STATUS, v); chk("status_full", v, 32'h106);
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    // reset in the middle of a DATA bit with three bytes waiting
    wr(ADR_DIVISOR, 32'd1);
    for (int i = 0; i < 4; i++) wr(ADR_TXDATA, 32'h00);
    @(negedge clk); chk("line_data_before_reset", tx_o, 0);
    #2 rst_n = 0;
    #1 chk("async_line", tx_o, 1); chk("async_ack", ack_o, 0); chk("async_int", int_o, 0);
    repeat (3) @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    rd(ADR_STATUS, v);  chk("status_post_reset", v, 32'h1);
    rd(ADR_DIVISOR, v); chk("divisor_post_reset", v, 32'd433);
    lows = 0;
    repeat (60) begin @(negedge clk); if (!tx_o) lows++; end
    chk("quiet_after_reset", lows, 0);
    // random traffic
    @(posedge clk); #1;
    wr(ADR_DIVISOR, 32'd1);
    for (int n = 0; n < 700; n++) begin
      logic [2:0] a; logic we; logic [3:0] sel; logic [31:0] d;
      a   = $urandom_range(0, 1) ? ADR_TXDATA : 3'($urandom_range(0, 7));
      we  = 1'($urandom);
      sel = 4'($urandom);
      d   = $urandom;
      if (a == ADR_DIVISOR) d[15:0] = 16'($urandom_range(0, 3));
      if (a == ADR_TXDATA && we && mq.size() == DEPTH) sel[0] = 1'b1;
      xfer(we, {19'($urandom), a, 2'($urandom)}, d, sel, k, e, v);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
